// File: rtl/redtin_pkg.sv
// Shared definitions for the RedTin capture engine: FSM state encoding and
// an elaboration-time log2 helper for address widths.
package redtin_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WAIT,
        ST_POST,
        ST_DONE
    } state_t;

    // Ceiling log2, used to size pointers and read addresses from DEPTH.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/redtin_capture_ram.sv
// Sample buffer: one write port, one registered read port (WIDTH x DEPTH).
// The read register clears on reset and holds its value when not read.
module redtin_capture_ram
    import redtin_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 512
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we,
    input  logic [clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic                      re,
    input  logic [clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store one sample per enabled cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; output holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/redtin_capture_core.sv
// RedTin capture core: circular pre-trigger buffering, mask/value/edge
// trigger, post-trigger fill, then frozen trigger-aligned readout.
module redtin_capture_core
    import redtin_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned PRETRIG = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          din,
    input  logic                      arm,
    input  logic                      abort,
    input  logic [WIDTH-1:0]          trig_mask,
    input  logic [WIDTH-1:0]          trig_value,
    input  logic [WIDTH-1:0]          trig_edge,
    input  logic                      rd_en,
    input  logic [clog2(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    output logic                      armed,
    output logic                      triggered,
    output logic                      done
);

    localparam int unsigned   AW        = clog2(DEPTH);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRETRIG);
    // With PRETRIG=0 this wraps, but FILL is never entered in that case.
    localparam logic [AW-1:0] FILL_LAST = AW'(PRETRIG - 1);
    localparam logic [AW-1:0] POST_LOAD = AW'(DEPTH - PRETRIG - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] mask_q, value_q, edge_q, din_prev;
    logic [AW-1:0]    wr_ptr, start_ptr, cnt;
    logic             trig_hit, start_cap, fire, wr_en, rd_fire;

    // Trigger: masked bits at the required level and every edge bit toggled.
    always_comb begin
        trig_hit = (((din ^ value_q) & mask_q) == '0) &&
                   (((din ^ din_prev) & edge_q) == edge_q);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and datapath strobes; abort overrides arm and trigger.
    always_comb begin
        state_n   = state;
        start_cap = 1'b0;
        fire      = 1'b0;
        wr_en     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    start_cap = 1'b1;
                    state_n   = (PRETRIG > 0) ? ST_FILL : ST_WAIT;
                end
            end
            ST_FILL: begin
                wr_en = 1'b1;
                if (cnt == FILL_LAST) begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wr_en = 1'b1;
                if (trig_hit) begin
                    fire    = 1'b1;
                    state_n = (POST_LOAD == '0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                wr_en = 1'b1;
                if (cnt == AW'(1)) begin
                    state_n = ST_DONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (abort && state != ST_IDLE) begin
            state_n   = ST_IDLE;
            start_cap = 1'b0;
            fire      = 1'b0;
        end
    end

    // Config latch, write pointer, fill/post counter and trigger anchor.
    // The single counter counts up through FILL and down through POST.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q    <= '0;
            value_q   <= '0;
            edge_q    <= '0;
            din_prev  <= '0;
            wr_ptr    <= '0;
            start_ptr <= '0;
            cnt       <= '0;
        end else begin
            din_prev <= din;
            if (start_cap) begin
                mask_q  <= trig_mask;
                value_q <= trig_value;
                edge_q  <= trig_edge;
                wr_ptr  <= '0;
                cnt     <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (fire) begin
                    start_ptr <= wr_ptr - PRE_OFS;
                    cnt       <= POST_LOAD;
                end else if (state == ST_FILL) begin
                    cnt <= cnt + AW'(1);
                end else if (state == ST_POST) begin
                    cnt <= cnt - AW'(1);
                end
            end
        end
    end

    // Reads are honoured only once the buffer is frozen.
    always_comb begin
        rd_fire = rd_en && (state == ST_DONE);
    end

    // Read-valid flag, aligned with the registered RAM output.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        armed     = (state == ST_FILL) || (state == ST_WAIT);
        triggered = (state == ST_POST) || (state == ST_DONE);
        done      = (state == ST_DONE);
    end

    redtin_capture_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (rd_fire),
        .raddr (start_ptr + rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_redtin_capture_core.sv
// Scoreboard bench for redtin_capture_core (WIDTH=8, DEPTH=16, PRETRIG=4).
module tb_redtin_capture_core;

    localparam int W   = 8;
    localparam int D   = 16;
    localparam int PRE = 4;

    logic         clk, reset, arm, abort, rd_en;
    logic [W-1:0] din, trig_mask, trig_value, trig_edge, rd_data;
    logic [3:0]   rd_addr;
    logic         rd_valid, armed, triggered, done;

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] hist[$];
    logic [W-1:0] cap[D];
    logic [W-1:0] cfg_m, cfg_v, cfg_e;
    logic [W-1:0] last_exp;
    bit           rec;
    int           cap_t, cap_done_at;

    redtin_capture_core #(
        .WIDTH   (W),
        .DEPTH   (D),
        .PRETRIG (PRE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .arm        (arm),
        .abort      (abort),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .trig_edge  (trig_edge),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .armed      (armed),
        .triggered  (triggered),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented read result is matched against the queue.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL rd_unexpected: got valid data %0h expected no valid", rd_data);
            end else begin
                check("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        if (rec) hist.push_back(din);
        @(posedge clk);
        #1;
    endtask

    task automatic cnt_tick();
        din = din + 8'd1;
        tick();
    endtask

    task automatic arm_cfg(input logic [W-1:0] m, input logic [W-1:0] v,
                           input logic [W-1:0] e, input logic [W-1:0] d);
        cfg_m = m; cfg_v = v; cfg_e = e;
        trig_mask = m; trig_value = v; trig_edge = e;
        din = d;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        trig_mask = $urandom; trig_value = $urandom; trig_edge = $urandom;
    endtask

    // Reference: first sample at or after the pre-trigger window satisfying the rule.
    function automatic int find_trigger();
        for (int i = PRE; i < hist.size(); i++) begin
            if ((((hist[i] ^ cfg_v) & cfg_m) == 8'h00) &&
                (((hist[i] ^ hist[i-1]) & cfg_e) == cfg_e))
                return i;
        end
        return -1;
    endfunction

    // Drive din after arm until done (bounded), then compare timing to the model.
    task automatic capture(input int mode, input int budget);
        int trig_at, t, exp_trig, exp_done;
        trig_at = -1;
        cap_done_at = -1;
        hist.delete();
        rec = 1'b1;
        for (int n = 0; n < budget && cap_done_at < 0; n++) begin
            case (mode)
                0: din = din + 8'd1;
                1: din = 8'($urandom);
                default: begin
                    if (n < 8)       din = 8'h00;
                    else if (n < 10) din = 8'h02;
                    else if (n < 12) din = 8'h00;
                    else if (n == 12) din = 8'h10;
                    else             din = 8'($urandom);
                end
            endcase
            tick();
            if (triggered && trig_at < 0) trig_at = hist.size();
            if (done) cap_done_at = hist.size();
        end
        rec = 1'b0;
        t = find_trigger();
        exp_trig = (t < 0) ? -1 : t + 1;
        exp_done = (t < 0 || t + D - PRE > budget) ? -1 : t + D - PRE;
        if (exp_done < 0 && t >= 0 && t + 1 > budget) exp_trig = -1;
        check("trigger_cycle", trig_at, exp_trig);
        check("done_cycle", cap_done_at, exp_done);
        cap_t = (exp_done >= 0) ? t : -1;
        if (cap_t >= 0)
            for (int a = 0; a < D; a++) cap[a] = hist[cap_t - PRE + a];
        if (!done) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end
    endtask

    task automatic rd(input int a, input logic [W-1:0] expv);
        rd_en = 1'b1;
        rd_addr = 4'(a);
        exp_q.push_back(expv);
        last_exp = expv;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        tick();
        tick();
        check("sb_drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic sweep();
        int off;
        off = $urandom_range(0, 15);
        for (int k = 0; k < D; k++) rd((k * 7 + off) & 15, cap[(k * 7 + off) & 15]);
        drain();
    endtask

    initial begin
        logic [W-1:0] m, v, e;
        reset = 1'b1; arm = 1'b0; abort = 1'b0; rd_en = 1'b0; rd_addr = '0;
        din = 8'h00; trig_mask = '0; trig_value = '0; trig_edge = '0;
        rec = 1'b0; last_exp = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_armed", armed, 0);
        check("rst_triggered", triggered, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);

        // Level trigger on 0x20 with a counting probe.
        arm_cfg(8'hFF, 8'h20, 8'h00, 8'h00);
        capture(0, 60);
        rd(0, 8'h1C); rd(4, 8'h20); rd(15, 8'h2B);
        drain();
        sweep();

        // Match during FILL is ignored; next match after the counter wraps.
        arm_cfg(8'hFF, 8'h06, 8'h00, 8'h05);
        capture(0, 400);
        rd(4, 8'h06); rd(0, 8'h02);
        drain();
        sweep();

        // Edge trigger on bit 4; bit-1 toggles must not fire.
        arm_cfg(8'h00, 8'h00, 8'h10, 8'h00);
        capture(2, 60);
        rd(4, 8'h10); rd(3, 8'h00);
        drain();
        sweep();

        // Always-true trigger fires on the first WAIT sample.
        arm_cfg(8'h00, 8'h00, 8'h00, 8'($urandom));
        capture(1, 60);
        check("always_done_cycle", cap_done_at, D);
        sweep();

        // Back-to-back readout in DONE.
        begin
            int addrs[3] = '{0, 5, 15};
            for (int k = 0; k < 3; k++) begin
                rd_en = 1'b1;
                rd_addr = 4'(addrs[k]);
                exp_q.push_back(cap[addrs[k]]);
                last_exp = cap[addrs[k]];
                tick();
                check("b2b_valid", rd_valid, 1);
            end
            rd_en = 1'b0;
            tick();
            check("b2b_valid_end", rd_valid, 0);
            drain();
        end

        // Read during WAIT, then abort in POST.
        arm_cfg(8'hFF, 8'h4C, 8'h00, 8'h40);
        for (int k = 0; k < 5; k++) cnt_tick();
        check("wait_armed", armed, 1);
        rd_en = 1'b1; rd_addr = 4'd3;
        cnt_tick();
        rd_en = 1'b0;
        check("rd_in_wait_valid", rd_valid, 0);
        for (int k = 0; k < 20 && !triggered; k++) cnt_tick();
        check("abort_pre_trig", triggered, 1);
        cnt_tick(); cnt_tick();
        abort = 1'b1;
        cnt_tick();
        abort = 1'b0;
        check("abort_triggered", triggered, 0);
        check("abort_done", done, 0);
        check("abort_armed", armed, 0);
        rd_en = 1'b1; rd_addr = 4'd0;
        tick();
        rd_en = 1'b0;
        check("abort_rd_valid", rd_valid, 0);
        check("abort_rd_hold", rd_data, last_exp);

        // Reset during WAIT, then a clean restart.
        arm_cfg(8'h00, 8'h00, 8'hFF, 8'h30);
        for (int k = 0; k < 6; k++) cnt_tick();
        check("wait2_armed", armed, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_armed", armed, 0);
        check("mid_rst_triggered", triggered, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rd_valid", rd_valid, 0);
        check("mid_rst_rd_data", rd_data, 0);
        v = din + 8'd20;
        arm_cfg(8'hFF, v, 8'h00, din);
        capture(0, 60);
        sweep();

        // Randomized trigger configurations on random probe data.
        for (int r = 0; r < 6; r++) begin
            m = 8'($urandom) & 8'($urandom) & 8'($urandom);
            v = 8'($urandom);
            e = ($urandom_range(0, 1) == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            arm_cfg(m, v, e, 8'($urandom));
            capture(1, 300);
            if (cap_t >= 0) sweep();
        end

        check("sb_final_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/redtin_capture_core.md
Name: redtin_capture_core

Overview:
- Parametrised sampling engine for the RedTin logic analyzer.
- Captures a WIDTH-bit probe bus into a circular buffer of DEPTH samples, holding PRETRIG samples ahead of a mask/value/edge trigger.
- Freezes the buffer on completion and serves trigger-aligned readout to the UART host-interface logic.
- Sits between the probe inputs and the command/readout FSM of the hardware testbench top level.

Parameters:
- WIDTH, 32: probe bus width in bits (1..128).
- DEPTH, 512: samples stored; must be a power of two, at least 4.
- PRETRIG, 64: samples kept before the trigger sample; must be less than DEPTH.

Ports:
- clk  in  1  sample and system clock.
- reset  in  1  synchronous, active-high reset.
- din  in  WIDTH  probe data, sampled every clk.
- arm  in  1  one-cycle pulse: start a capture.
- abort  in  1  one-cycle pulse: cancel capture and return to IDLE.
- trig_mask  in  WIDTH  1 = bit participates in the level compare.
- trig_value  in  WIDTH  required level for masked bits.
- trig_edge  in  WIDTH  1 = bit must have changed since the previous sample.
- rd_en  in  1  readout request.
- rd_addr  in  log2(DEPTH)  sample index; 0 = oldest sample, PRETRIG = trigger sample.
- rd_data  out  WIDTH  read data.
- rd_valid  out  1  rd_data valid.
- armed  out  1  high in FILL or WAIT.
- triggered  out  1  high in POST or DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset (sync, active-high):
  - State = IDLE; write pointer 0; counters 0.
  - All outputs 0, including rd_data.
  - Reset asserted mid-capture discards the capture. Buffer contents need not clear.
- States: IDLE, FILL, WAIT, POST, DONE.
- IDLE:
  - Nothing written.
  - arm: latch trig_mask, trig_value and trig_edge into config registers; zero the write pointer and fill counter; go to FILL (PRETRIG>0) or WAIT (PRETRIG=0).
- FILL:
  - Write din at wr_ptr every cycle; wr_ptr increments modulo DEPTH.
  - The trigger is ignored.
  - After PRETRIG writes, go to WAIT, which guarantees a full pre-trigger window.
- WAIT:
  - Write every cycle, circularly.
  - Trigger condition is true when ((din ^ value_q) & mask_q)==0 AND ((din ^ din_prev) & edge_q)==0 is false for no edge bit. That is: every edge-selected bit must differ from din_prev.
  - din_prev is the previous-cycle din, registered in every state.
  - If mask_q and edge_q are both 0, the trigger fires on the first WAIT cycle.
  - On trigger, in the same cycle:
    - din is written as the trigger sample.
    - start_ptr latches (wr_ptr - PRETRIG) mod DEPTH.
    - The post counter loads DEPTH-PRETRIG-1.
    - Go to POST, or straight to DONE if DEPTH-PRETRIG-1 = 0.
- POST:
  - Write every cycle; decrement the counter.
  - On the cycle the counter reaches 0, after that sample is written, go to DONE.
  - Total samples after the trigger, including it, = DEPTH-PRETRIG.
- DONE:
  - No writes; the buffer is frozen.
  - arm restarts from IDLE behaviour: it reloads config and goes to FILL the next cycle.
- Overlapping control:
  - arm is ignored in FILL, WAIT and POST.
  - abort in any non-IDLE state goes to IDLE next cycle and overrides a simultaneous arm or trigger.
  - abort in IDLE is a no-op.
- Readout:
  - rd_en in cycle N gives rd_data = mem[(start_ptr + rd_addr) mod DEPTH] and rd_valid=1 in cycle N+1.
  - Back-to-back reads sustain one per cycle.
  - rd_valid asserts only for requests made while done=1. Requests in other states produce rd_valid=0, and rd_data holds its prior value.
- Width rules:
  - All pointer arithmetic is log2(DEPTH) bits, wrapping naturally.
  - The post counter is log2(DEPTH) bits.
- The buffer is inferred block RAM: one write port, one registered read port, no read-during-write hazard, because reads are only valid in DONE.

Decomposition:
- Shared package redtin_pkg holds:
  - State encoding constants (IDLE/FILL/WAIT/POST/DONE).
  - A function clog2 for address widths.
- One sub-module: redtin_capture_ram, a simple dual-port RAM (WIDTH x DEPTH) with a synchronous registered read port.
- Trigger compare and FSM stay in the core.

Test Plan:
All tests use WIDTH=8, DEPTH=16, PRETRIG=4, with din = 8-bit counter incrementing each clk from 0x00.
- Level trigger: arm, mask=0xFF, value=0x20 -> triggered rises the cycle after din=0x20; done after 12 samples total from the trigger. Reading addr 0..15 returns 0x1C..0x2B; addr 4 = 0x20.
- Early match suppressed: arm while din=0x05, value=0x06 (matches during FILL) -> no trigger at 0x06; next match at 0x106 wrap (0x06 again after 256 cycles). Reading addr 4 returns 0x06 and addr 0 returns 0x02.
- Edge trigger: mask=0, edge=0x10 with din held at 0x00, then stepped to 0x10 -> trigger on the 0x10 sample. Stepping bit 1 only does not trigger.
- Always-true trigger: mask=0, edge=0 -> trigger on the first WAIT cycle. The addr 0..3 samples are the 4 FILL samples, and done is asserted exactly 16 cycles after arm+1.
- Abort/reset mid-capture: abort in POST -> IDLE next cycle, done=0, triggered=0. A read issued then gives rd_valid=0. reset during WAIT -> all outputs 0. A following arm restarts cleanly.
- Readout timing: in DONE, rd_en on 3 consecutive cycles with addr 0,5,15 -> rd_valid high for 3 consecutive cycles starting one cycle later, with data in request order. rd_en while in WAIT -> rd_valid stays 0.
